// File: rtl/rv_register_file.sv
// RV32I integer register file: 32 x XLEN registers, two combinational read
// ports with write-through bypass from the write port, x0 hardwired to zero.
module rv_register_file #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic              RegWrite,
  input  logic [XLEN-1:0]   in,
  output logic [XLEN-1:0]   out1,
  output logic [XLEN-1:0]   out2
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  // Entry 0 is cleared on reset and never written; reads of x0 are forced to
  // zero anyway so it reads 0 even before the first reset.
  logic [XLEN-1:0] mem_q [NumRegs];

  logic wr_en;
  assign wr_en = RegWrite && (rd != '0);

  // Storage update: reset clears every register and wins over a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[rd] <= in;
    end
  end

  // Read ports: zero for x0, else bypass the in-flight write, else storage.
  always_comb begin
    out1 = mem_q[rs1];
    out2 = mem_q[rs2];
    if (rs1 == '0) begin
      out1 = '0;
    end else if (wr_en && (rd == rs1)) begin
      out1 = in;
    end
    if (rs2 == '0) begin
      out2 = '0;
    end else if (wr_en && (rd == rs2)) begin
      out2 = in;
    end
  end

endmodule

// File: tb/tb_rv_register_file.sv
// Self-checking bench for rv_register_file: directed vectors with literal
// expectations plus a per-cycle comparison against an array model.
module tb_rv_register_file;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        RegWrite;
  logic [31:0] in;
  logic [31:0] out1;
  logic [31:0] out2;

  int unsigned n_cmp;
  int unsigned n_err;

  // Model: architectural register contents, updated on each rising edge.
  logic [31:0] model [32];
  bit          armed;

  rv_register_file #(
    .XLEN  (32),
    .ADDR_W(5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rs1     (rs1),
    .rs2     (rs2),
    .rd      (rd),
    .RegWrite(RegWrite),
    .in      (in),
    .out1    (out1),
    .out2    (out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value a read of register a must return right now.
  function automatic logic [31:0] expect_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (RegWrite && rd == a) return in;
    return model[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] <= 32'd0;
      armed <= 1'b1;
    end else if (RegWrite && rd != 5'd0) begin
      model[rd] <= in;
    end
  end

  // Continuous compare at mid-cycle, once the contents are defined.
  always @(negedge clk) begin
    if (armed) begin
      n_cmp++;
      if (out1 !== expect_rd(rs1)) begin
        n_err++;
        $display("FAIL model_out1 t=%0t rs1=%0d got=%h exp=%h", $time, rs1, out1, expect_rd(rs1));
      end
      n_cmp++;
      if (out2 !== expect_rd(rs2)) begin
        n_err++;
        $display("FAIL model_out2 t=%0t rs2=%0d got=%h exp=%h", $time, rs2, out2, expect_rd(rs2));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // Advance one edge; inputs then change 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    armed = 1'b0;
    rst = 1'b1; RegWrite = 1'b0; rd = '0; rs1 = '0; rs2 = '0; in = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    rs1 = 5'd9; rs2 = 5'd31;
    #1;
    chk("reset_out1", out1, 32'd0);
    chk("reset_out2", out2, 32'd0);
    step();

    // Write-through
    rs1 = 5'd1; rs2 = 5'd1; rd = 5'd1; in = 32'd5; RegWrite = 1'b0;
    #1;
    chk("wt_before_we", out1, 32'd0);
    RegWrite = 1'b1;
    #1;
    chk("wt_bypass1", out1, 32'd5);
    chk("wt_bypass2", out2, 32'd5);
    step();
    RegWrite = 1'b0;
    #1;
    chk("wt_stored", out1, 32'd5);
    step();

    // x0 never written
    rd = 5'd0; in = 32'hDEADBEEF; RegWrite = 1'b1; rs1 = 5'd0;
    #1;
    chk("x0_before", out1, 32'd0);
    step();
    RegWrite = 1'b0;
    #1;
    chk("x0_after", out1, 32'd0);
    step();

    // Dual read
    RegWrite = 1'b1; rd = 5'd3; in = 32'h1234;
    step();
    rd = 5'd7; in = 32'hFFFF_0000;
    step();
    RegWrite = 1'b0; rs1 = 5'd3; rs2 = 5'd7;
    #1;
    chk("dual_out1", out1, 32'h1234);
    chk("dual_out2", out2, 32'hFFFF_0000);
    rs1 = 5'd7;
    #1;
    chk("same_out1", out1, 32'hFFFF_0000);
    chk("same_out2", out2, 32'hFFFF_0000);
    step();

    // Write disable
    RegWrite = 1'b1; rd = 5'd4; in = 32'd9;
    step();
    RegWrite = 1'b0; in = 32'd1; rs1 = 5'd4; rs2 = 5'd4;
    repeat (3) step();
    chk("wdis_out1", out1, 32'd9);
    chk("wdis_out2", out2, 32'd9);

    // Reset beats a write
    RegWrite = 1'b1;
    for (int i = 1; i < 32; i++) begin
      rd = 5'(i); in = 32'(i);
      step();
    end
    rst = 1'b1; rd = 5'd5; in = 32'd77;
    step();
    rst = 1'b0; RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(i);
      #1;
      chk("rst_clear1", out1, 32'd0);
      chk("rst_clear2", out2, 32'd0);
      step();
    end

    // Sweep
    RegWrite = 1'b1;
    for (int i = 1; i < 32; i++) begin
      rd = 5'(i); in = ~32'(i);
      step();
    end
    RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #1;
      chk("sweep_out1", out1, (i == 0) ? 32'd0 : ~32'(i));
      chk("sweep_out2", out2, (i == 31) ? 32'd0 : ~32'(31 - i));
      step();
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
